// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, register-file geometry and word/index types
package mips_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [ADDR_WIDTH-1:0] REG_ZERO = 5'd0;
    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port with r0 mask and write-through bypass
//   regs : storage array        idx : read index
//   wa   : write index          wd  : write data
//   we   : qualified write strobe (enable, out of reset, wa != 0)
//   q    : read data
module rf_read_port
    import mips_pkg::*;
(
    input  word_t    regs [NUM_REGS],
    input  reg_idx_t idx,
    input  reg_idx_t wa,
    input  word_t    wd,
    input  logic     we,
    output word_t    q
);
    assign q = (idx == REG_ZERO) ? '0 : (we && wa == idx) ? wd : regs[idx];
endmodule

// File: rtl/register_file.sv
// register_file: 32x32 MIPS register file, two combinational reads, one clocked write
//   clk       : write clock          rst  : async active-low reset, clears all registers
//   din       : write-back data      writeBack : write enable
//   rd        : write index          rs/rt : read indices for ports A/B
//   regA/regB : read data for rs/rt, bypassing din when a write targets the same index
module register_file
    import mips_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  word_t    din,
    input  logic     writeBack,
    input  reg_idx_t rd,
    input  reg_idx_t rs,
    input  reg_idx_t rt,
    output word_t    regA,
    output word_t    regB
);
    word_t regs [NUM_REGS];
    logic  we;
    // Gating with rst makes reset override the bypass; storage is already zero then.
    assign we = writeBack && rst && (rd != REG_ZERO);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[rd] <= din;
        end
    end
    rf_read_port u_port_a (.regs(regs), .idx(rs), .wa(rd), .wd(din), .we(we), .q(regA));
    rf_read_port u_port_b (.regs(regs), .idx(rt), .wa(rd), .wd(din), .we(we), .q(regB));
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed plus random checks of register_file against an array model
module tb_register_file;
    logic        clk = 0, rst = 0, writeBack = 0;
    logic [31:0] din = 0;
    logic [4:0]  rd = 0, rs = 0, rt = 0;
    logic [31:0] regA, regB;
    logic [31:0] m [32];
    int checks = 0, failures = 0;

    register_file dut (.clk(clk), .rst(rst), .din(din), .writeBack(writeBack),
                       .rd(rd), .rs(rs), .rt(rt), .regA(regA), .regB(regB));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] expect_rd(input logic [4:0] i);
        if (!rst || i == 0) return 0;
        if (writeBack && rd != 0 && rd == i) return din;
        return m[i];
    endfunction

    task automatic step(input string tag, input logic we, input logic [4:0] a,
                        input logic [31:0] d, input logic [4:0] s, input logic [4:0] t);
        writeBack = we; rd = a; din = d; rs = s; rt = t;
        #1;
        check({tag, "_a"}, regA, expect_rd(rs));
        check({tag, "_b"}, regB, expect_rd(rt));
        @(posedge clk);
        if (rst && writeBack && rd != 0) m[rd] = din;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m[i] = 0;
        step("rst0", 0, 0, 0, 3, 7);
        step("rst_wr", 1, 3, 32'd55, 3, 3);
        @(negedge clk);
        rst = 1;
        step("post_rst", 0, 0, 0, 3, 31);
        step("w1", 1, 1, 32'd2001, 0, 0);
        step("w2", 1, 2, 32'd4001, 1, 0);
        step("w6", 1, 6, 32'd8002, 2, 1);
        step("w8", 1, 8, 32'd3002, 6, 2);
        step("r12", 0, 0, 0, 1, 2);
        check("r1_const", regA, 32'd2001);
        check("r2_const", regB, 32'd4001);
        step("r68", 0, 0, 0, 6, 8);
        check("r6_const", regA, 32'd8002);
        check("r8_const", regB, 32'd3002);
        step("r0w", 1, 0, 32'hDEADBEEF, 0, 0);
        step("r0r", 0, 0, 0, 0, 0);
        check("r0_const", regA, 32'd0);
        for (int k = 0; k < 3; k++) step("wdis", 0, 1, 32'd7, 1, 1);
        check("r1_kept", regA, 32'd2001);
        step("byp", 1, 5, 32'h1234, 5, 5);
        step("byp_after", 0, 5, 0, 5, 5);
        check("r5_const", regB, 32'h1234);
        for (int k = 0; k < 400; k++) begin
            logic [4:0] a, s, t;
            a = 5'($urandom);
            s = ($urandom % 4 == 0) ? a : 5'($urandom);
            t = ($urandom % 4 == 0) ? a : 5'($urandom);
            step("rnd", 1'($urandom), a, $urandom, s, t);
        end
        // Asynchronous reset between edges, held across an enabled write edge.
        writeBack = 1; rd = 9; din = 32'hABCD;
        #2 rst = 0;
        for (int i = 0; i < 32; i++) m[i] = 0;
        for (int i = 0; i < 32; i++) begin
            rs = 5'(i); rt = 5'(31 - i);
            #1;
            check("async_a", regA, 32'd0);
            check("async_b", regB, 32'd0);
        end
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 32; i++) step("post_async", 0, 0, 0, 5'(i), 5'(31 - i));
        step("w_after_rst", 1, 4, 32'h55AA, 0, 0);
        step("r_after_rst", 0, 0, 0, 4, 9);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
